pcx_rr_arbiter: RTL and testbench

- Shares the single 32-bit max_pcx output stream between NUM_CORES SPARC cores.
- Round-robin arbitration over the cores' PCX requests (req/atom/data_pa).
- Returns the per-core PCX grant.
- Serialises each granted 124-bit packet into four 32-bit words under a valid/stall handshake.
- Sits between multiple SPARC core instances and the Maxeler-side PCX stream interface.

---
 rtl/pcx_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_pcx_rr_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pcx_rr_arbiter.sv
// Round-robin PCX arbiter: grants one core at a time and streams its 128-bit frame as four 32-bit words.
// Define PCX_ARB_PERF_EN to add the perf_pkt_cnt / perf_stall_cnt counters.
module pcx_rr_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int PCX_W     = 124
) (
   input  logic                       gclk,
   input  logic                       reset_l,
   input  logic [5*NUM_CORES-1:0]     spc_pcx_req_pq,
   input  logic [NUM_CORES-1:0]       spc_pcx_atom_pq,
   input  logic [PCX_W*NUM_CORES-1:0] spc_pcx_data_pa,
   output logic [5*NUM_CORES-1:0]     pcx_spc_grant_px,
   output logic                       max_pcx_valid,
   output logic [31:0]                max_pcx_data,
   input  logic                       max_pcx_stall
`ifdef PCX_ARB_PERF_EN
   ,
   output logic [31:0]                perf_pkt_cnt,
   output logic [31:0]                perf_stall_cnt
`endif
);

   localparam int FRAME_W = PCX_W + 4;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state;
   logic [2:0]             rr_ptr;
   logic [2:0]             lock_core;
   logic                   lock;
   logic [1:0]             word_cnt;
   logic [FRAME_W-1:0]     frame_sr;

   logic                   found;
   logic [2:0]             sel;
   logic                   atom_sel;
   logic [4:0]             req_sel;
   logic [PCX_W-1:0]       data_sel;
   logic [5*NUM_CORES-1:0] grant_next;
   int                     ring_dist;
   int                     best_dist;

   // Winner = requester nearest to rr_ptr going upwards, unless an atomic pair pins the lock owner.
   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      found      = 1'b0;
      sel        = '0;
      atom_sel   = 1'b0;
      req_sel    = '0;
      data_sel   = '0;
      grant_next = '0;
      best_dist  = NUM_CORES;
      ring_dist  = 0;
      for (int i = 0; i < NUM_CORES; i++) begin
         ring_dist = (i + NUM_CORES - int'(rr_ptr)) % NUM_CORES;
         if ((|spc_pcx_req_pq[5*i +: 5]) &&
             (lock ? (i == int'(lock_core)) : (ring_dist < best_dist))) begin
            found     = 1'b1;
            sel       = 3'(i);
            best_dist = ring_dist;
            atom_sel  = spc_pcx_atom_pq[i];
            req_sel   = spc_pcx_req_pq[5*i +: 5];
            data_sel  = spc_pcx_data_pa[PCX_W*i +: PCX_W];
         end
      end
      for (int i = 0; i < NUM_CORES; i++) begin
         if (found && (sel == 3'(i))) grant_next[5*i +: 5] = req_sel;
      end
   end

   assign max_pcx_data = frame_sr[FRAME_W-1 -: 32];

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge gclk) begin
      if (!reset_l) begin
         state            <= IDLE;
         rr_ptr           <= '0;
         lock             <= 1'b0;
         lock_core        <= '0;
         word_cnt         <= '0;
         // NOTE: the frame register is cleared too, since it drives max_pcx_data directly.
         frame_sr         <= '0;
         pcx_spc_grant_px <= '0;
         max_pcx_valid    <= 1'b0;
      end else begin
         pcx_spc_grant_px <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  frame_sr         <= {sel, atom_sel, data_sel};
                  pcx_spc_grant_px <= grant_next;
                  word_cnt         <= '0;
                  max_pcx_valid    <= 1'b1;
                  state            <= SEND;
                  rr_ptr           <= 3'((int'(sel) + 1) % NUM_CORES);
                  if (lock) begin
                     lock <= 1'b0;
                  end else if (atom_sel) begin
                     lock      <= 1'b1;
                     lock_core <= sel;
                  end
               end else begin
                  max_pcx_valid <= 1'b0;
               end
            end
            SEND: begin
               if (!max_pcx_stall) begin
                  if (word_cnt != 2'd3) begin
                     frame_sr <= frame_sr << 32;
                     word_cnt <= word_cnt + 2'd1;
                  end else begin
                     max_pcx_valid <= 1'b0;
                     state         <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PCX_ARB_PERF_EN
   always_ff @(posedge gclk) begin
      if (!reset_l) begin
         perf_pkt_cnt   <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (max_pcx_valid && max_pcx_stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (state == SEND && max_pcx_valid && !max_pcx_stall && word_cnt == 2'd3)
            perf_pkt_cnt <= perf_pkt_cnt + 32'd1;
      end
   end
`else
   // Counters absent in this build.
`endif

endmodule

// File: tb/tb_pcx_rr_arbiter.sv
// Self-checking bench for pcx_rr_arbiter: frame-queue reference model checked every cycle plus directed literal checks.
module tb_pcx_rr_arbiter;
   localparam int N = 2;
   localparam int W = 124;
   localparam logic [W-1:0] D0 = 124'h0123_4567_89AB_CDEF_0123_4567_89AB_CDE;
   localparam logic [W-1:0] D1 = 124'hABC_DEF0_1234_5678_9ABC_DEF0_1234_5678;

   logic           gclk = 1'b0;
   logic           reset_l;
   logic [5*N-1:0] req;
   logic [N-1:0]   atom;
   logic [W*N-1:0] data;
   logic           stall;
   logic [5*N-1:0] grant;
   logic           valid;
   logic [31:0]    word;
`ifdef PCX_ARB_PERF_EN
   logic [31:0]    perf_pkt_cnt;
   logic [31:0]    perf_stall_cnt;
`endif

   pcx_rr_arbiter #(.NUM_CORES(N), .PCX_W(W)) dut (
      .gclk             (gclk),
      .reset_l          (reset_l),
      .spc_pcx_req_pq   (req),
      .spc_pcx_atom_pq  (atom),
      .spc_pcx_data_pa  (data),
      .pcx_spc_grant_px (grant),
      .max_pcx_valid    (valid),
      .max_pcx_data     (word),
      .max_pcx_stall    (stall)
`ifdef PCX_ARB_PERF_EN
      ,
      .perf_pkt_cnt     (perf_pkt_cnt),
      .perf_stall_cnt   (perf_stall_cnt)
`endif
   );

   always #5 gclk = ~gclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge gclk);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      @(negedge gclk);
      reset_l = 1'b0;
      req     = '0;
      atom    = '0;
      stall   = 1'b0;
      repeat (cycles) @(negedge gclk);
   endtask

   // Reference model: a queue of words still owed downstream; empty queue means the arbiter is idle.
   logic [31:0]    mq[$];
   logic [5*N-1:0] m_grant;
   int             m_rr;
   int             m_lock_core;
   bit             m_lock;
   logic [31:0]    m_pkt;
   logic [31:0]    m_stall;
   logic [127:0]   m_frame;
   int             cand;

   always @(posedge gclk) begin
      m_grant = '0;
      if (!reset_l) begin
         mq.delete();
         m_rr = 0; m_lock = 0; m_lock_core = 0;
         m_pkt = '0; m_stall = '0;
      end else if (mq.size() != 0) begin
         if (stall) m_stall++;
         else begin
            void'(mq.pop_front());
            if (mq.size() == 0) m_pkt++;
         end
      end else begin
         cand = -1;
         if (m_lock) begin
            if (|req[m_lock_core*5 +: 5]) cand = m_lock_core;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (cand < 0 && |req[((m_rr + k) % N)*5 +: 5]) cand = (m_rr + k) % N;
            end
         end
         if (cand >= 0) begin
            m_frame = {3'(cand), atom[cand], data[cand*W +: W]};
            for (int w = 3; w >= 0; w--) mq.push_back(m_frame[32*w +: 32]);
            m_grant[cand*5 +: 5] = req[cand*5 +: 5];
            if (m_lock) m_lock = 0;
            else if (atom[cand]) begin m_lock = 1; m_lock_core = cand; end
            m_rr = (cand + 1) % N;
         end
      end
      #1;
      check("model_valid", 64'(valid), 64'(mq.size() != 0));
      check("model_grant", 64'(grant), 64'(m_grant));
      if (mq.size() != 0) check("model_word", 64'(word), 64'(mq[0]));
`ifdef PCX_ARB_PERF_EN
      check("model_perf_pkt", 64'(perf_pkt_cnt), 64'(m_pkt));
      check("model_perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
   end

   logic [5*N-1:0] g_q[$];
   logic [3:0]     w_q[$];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_l = 1'b0; req = '0; atom = '0; data = '0; stall = 1'b0;
      do_reset(2);
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_grant", 64'(grant), 64'd0);
      check("reset_word",  64'(word),  64'd0);

      // Single request from core0
      reset_l = 1'b1; req[4:0] = 5'b00001; data[W-1:0] = D0;
      tick();
      check("t1_grant", 64'(grant), 64'h001);
      check("t1_valid", 64'(valid), 64'd1);
      check("t1_w0",    64'(word),  64'h0012_3456);
      @(negedge gclk); req = '0;
      tick(); check("t1_grant_off", 64'(grant), 64'd0); check("t1_w1", 64'(word), 64'h789A_BCDE);
      tick(); check("t1_w2", 64'(word), 64'hF012_3456);
      tick(); check("t1_w3", 64'(word), 64'h789A_BCDE);
      tick(); check("t1_bubble", 64'(valid), 64'd0);

      // Contention: both cores request continuously
      do_reset(1);
      reset_l = 1'b1; req = {5'b00100, 5'b00010}; data = {D1, D0};
      g_q.delete(); w_q.delete();
      for (int i = 0; i < 12; i++) begin
         tick();
         if (grant != '0) begin g_q.push_back(grant); w_q.push_back({1'b0, word[31:29]}); end
      end
      check("t2_ngrants", 64'(g_q.size()), 64'd3);
      if (g_q.size() >= 3) begin
         check("t2_g0", 64'(g_q[0]), 64'h002); check("t2_c0", 64'(w_q[0]), 64'd0);
         check("t2_g1", 64'(g_q[1]), 64'h080); check("t2_c1", 64'(w_q[1]), 64'd1);
         check("t2_g2", 64'(g_q[2]), 64'h002); check("t2_c2", 64'(w_q[2]), 64'd0);
      end

      // Stall while word1 is presented
      do_reset(1);
      reset_l = 1'b1; req = {5'b10000, 5'b00000}; data = {D1, D0};
      tick(); check("t3_grant", 64'(grant), 64'h200); check("t3_w0", 64'(word), 64'h2ABC_DEF0);
      @(negedge gclk); req = '0;
      tick(); check("t3_w1", 64'(word), 64'h1234_5678);
      @(negedge gclk); stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t3_hold_word",  64'(word),  64'h1234_5678);
         check("t3_hold_valid", 64'(valid), 64'd1);
      end
      @(negedge gclk); stall = 1'b0;
      tick(); check("t3_w2", 64'(word), 64'h9ABC_DEF0);
      tick(); check("t3_w3", 64'(word), 64'h1234_5678);
      tick(); check("t3_done", 64'(valid), 64'd0);
`ifdef PCX_ARB_PERF_EN
      check("t3_perf_stall", 64'(perf_stall_cnt), 64'd3);
      check("t3_perf_pkt",   64'(perf_pkt_cnt),   64'd1);
`endif

      // Atomic lock: core1's atomic grant forces the next grant to core1
      do_reset(1);
      reset_l = 1'b1; req = {5'b01000, 5'b00001}; atom = 2'b10; data = {D1, D0};
      g_q.delete(); w_q.delete();
      for (int i = 0; i < 18; i++) begin
         tick();
         if (grant != '0) begin g_q.push_back(grant); w_q.push_back(word[31:28]); end
      end
      check("t4_ngrants", 64'(g_q.size()), 64'd4);
      if (g_q.size() >= 4) begin
         check("t4_g0", 64'(g_q[0]), 64'h001); check("t4_h0", 64'(w_q[0]), 64'h0);
         check("t4_g1", 64'(g_q[1]), 64'h100); check("t4_h1", 64'(w_q[1]), 64'h3);
         check("t4_g2", 64'(g_q[2]), 64'h100); check("t4_h2", 64'(w_q[2]), 64'h3);
         check("t4_g3", 64'(g_q[3]), 64'h001); check("t4_h3", 64'(w_q[3]), 64'h0);
      end

      // Reset mid-frame after word1 transfers
      do_reset(1);
      reset_l = 1'b1; req = {5'b00000, 5'b00001}; atom = '0; data = {D1, D0};
      tick(); check("t5_grant", 64'(grant), 64'h001);
      @(negedge gclk); req = '0;
      tick(); check("t5_w1", 64'(word), 64'h789A_BCDE);
      tick(); check("t5_w2", 64'(word), 64'hF012_3456);
      @(negedge gclk); reset_l = 1'b0; req = {5'b00100, 5'b00010};
      tick(); check("t5_rst_valid", 64'(valid), 64'd0); check("t5_rst_grant", 64'(grant), 64'd0);
      @(negedge gclk); reset_l = 1'b1;
      tick(); check("t5_regrant", 64'(grant), 64'h002); check("t5_restart_w0", 64'(word), 64'h0012_3456);
      @(negedge gclk); req = '0;
      repeat (6) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
